// File: rtl/eth_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_monitor_pkg
// Brief    : Shared FSM encoding and counter constants for the activity monitor
// Revision : 1.0
// ============================================================================
package eth_monitor_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } mon_state_t;

    localparam int c_cnt_width_default = 32;
    localparam int c_hold_cycles_default = 16;

endpackage : eth_monitor_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Statistics counter that sticks at all-ones; clear beats increment
// Revision : 1.0
// ============================================================================
module sat_counter
    import eth_monitor_pkg::*;
#(
    parameter int CNT_WIDTH = c_cnt_width_default
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] c_sat_max = '1;

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_sat_max)) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/eth_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module   : eth_activity_monitor
// Brief    : Zero-latency AXI-Stream tap with busy flag, packet FSM and stats
// Revision : 1.0
// ============================================================================
module eth_activity_monitor
    import eth_monitor_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int HOLD_CYCLES = c_hold_cycles_default,
    parameter int CNT_WIDTH   = c_cnt_width_default
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  logic [DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXIS_tkeep,
    input  logic                    S_AXIS_tlast,
    input  logic                    S_AXIS_tuser,
    input  logic                    S_AXIS_tvalid,
    output logic                    S_AXIS_tready,

    output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
    output logic                    M_AXIS_tlast,
    output logic                    M_AXIS_tuser,
    output logic                    M_AXIS_tvalid,
    input  logic                    M_AXIS_tready,

    input  logic                    clear_stats,
    output logic                    eth_busy,
    output logic                    in_packet,
    output logic [CNT_WIDTH-1:0]    packet_count,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic [CNT_WIDTH-1:0]    stall_count
);

    // A zero hold still needs a 1-bit counter; it simply never leaves zero.
    localparam int c_hold_w = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_CYCLES);

    logic                w_accept;
    logic                w_stall;
    logic                w_pkt_end;
    logic                w_err_end;
    logic [c_hold_w-1:0] r_hold;
    logic                r_busy;
    mon_state_t          r_state;
    logic                r_in_packet;

    assign M_AXIS_tdata  = S_AXIS_tdata;
    assign M_AXIS_tkeep  = S_AXIS_tkeep;
    assign M_AXIS_tlast  = S_AXIS_tlast;
    assign M_AXIS_tuser  = S_AXIS_tuser;
    assign M_AXIS_tvalid = S_AXIS_tvalid;
    assign S_AXIS_tready = M_AXIS_tready;

    assign w_accept  = S_AXIS_tvalid && M_AXIS_tready;
    assign w_stall   = S_AXIS_tvalid && !M_AXIS_tready;
    assign w_pkt_end = w_accept && S_AXIS_tlast;
    assign w_err_end = w_pkt_end && S_AXIS_tuser;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hold <= '0;
            r_busy <= 1'b0;
        end else begin
            if (S_AXIS_tvalid) begin
                r_hold <= c_hold_load;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - c_hold_w'(1);
            end
            r_busy <= S_AXIS_tvalid || (r_hold != '0);
        end
    end

    // A single-beat packet (tlast on the first beat) never enters ST_PKT.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_in_packet <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !S_AXIS_tlast) begin
                        r_state     <= ST_PKT;
                        r_in_packet <= 1'b1;
                    end
                end
                ST_PKT: begin
                    if (w_pkt_end) begin
                        r_state     <= ST_IDLE;
                        r_in_packet <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_packet <= 1'b0;
                end
            endcase
        end
    end

    assign eth_busy  = r_busy;
    assign in_packet = r_in_packet;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_pkt_end),
        .clr    (clear_stats),
        .count  (packet_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_err_end),
        .clr    (clear_stats),
        .count  (err_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_stall),
        .clr    (clear_stats),
        .count  (stall_count)
    );

endmodule : eth_activity_monitor
`default_nettype wire

// File: tb/tb_eth_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_activity_monitor
// Brief    : Directed stimulus with cycle-tagged scoreboard for the monitor
// Revision : 1.0
// ============================================================================
module tb_eth_activity_monitor;

    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tuser;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tuser;
    logic          m_tvalid;
    logic          m_tready;
    logic          clear_stats;
    logic          eth_busy;
    logic          in_packet;
    logic [CW-1:0] packet_count;
    logic [CW-1:0] err_count;
    logic [CW-1:0] stall_count;

    eth_activity_monitor #(
        .DATA_WIDTH  (DW),
        .HOLD_CYCLES (16),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tkeep  (s_tkeep),
        .S_AXIS_tlast  (s_tlast),
        .S_AXIS_tuser  (s_tuser),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tready (s_tready),
        .M_AXIS_tdata  (m_tdata),
        .M_AXIS_tkeep  (m_tkeep),
        .M_AXIS_tlast  (m_tlast),
        .M_AXIS_tuser  (m_tuser),
        .M_AXIS_tvalid (m_tvalid),
        .M_AXIS_tready (m_tready),
        .clear_stats   (clear_stats),
        .eth_busy      (eth_busy),
        .in_packet     (in_packet),
        .packet_count  (packet_count),
        .err_count     (err_count),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    // sel: 0 busy, 1 in_packet, 2 packet_count, 3 err_count, 4 stall_count, 5 tready
    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } chk_t;

    chk_t               sq[$];
    logic [DW+KW+1:0]   bq[$];
    int                 cyc = 0;
    int                 nchecks = 0;
    int                 nerrors = 0;
    logic [DW+KW+1:0]   m_exp;
    logic [DW+KW+1:0]   m_act;
    logic [31:0]        m_val;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sel_val(input int sel);
        case (sel)
            0:       return {31'b0, eth_busy};
            1:       return {31'b0, in_packet};
            2:       return 32'(packet_count);
            3:       return 32'(err_count);
            4:       return 32'(stall_count);
            default: return {31'b0, s_tready};
        endcase
    endfunction

    // Monitor: every presented output beat must match the next queued beat,
    // and every tagged status expectation is checked in its own cycle.
    always @(negedge clk) begin
        if (m_tvalid) begin
            m_act = {m_tdata, m_tkeep, m_tlast, m_tuser};
            nchecks++;
            if (bq.size() == 0) begin
                nerrors++;
                $display("FAIL beat_unexpected: got %h, required no beat", m_act);
            end else begin
                m_exp = bq.pop_front();
                if (m_act !== m_exp) begin
                    nerrors++;
                    $display("FAIL beat_passthrough: got %h, required %h", m_act, m_exp);
                end
            end
        end
        for (int i = sq.size() - 1; i >= 0; i--) begin
            if (sq[i].cyc <= cyc) begin
                m_val = sel_val(sq[i].sel);
                nchecks++;
                if (sq[i].cyc < cyc || m_val !== sq[i].val) begin
                    nerrors++;
                    $display("FAIL %s: got %0d, required %0d (cycle %0d)",
                             sq[i].name, m_val, sq[i].val, sq[i].cyc);
                end
                sq.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_at(input int dly, input int sel, input logic [31:0] v, input string nm);
        chk_t c;
        c.cyc  = cyc + dly;
        c.sel  = sel;
        c.val  = v;
        c.name = nm;
        sq.push_back(c);
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic l, input logic u);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        s_tvalid = 1'b1;
        bq.push_back({d, k, l, u});
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    initial begin
        resetn      = 1'b0;
        m_tready    = 1'b1;
        clear_stats = 1'b0;
        s_tdata     = '0;
        s_tkeep     = '0;
        idle();
        step();
        step();

        // Reset state
        exp_at(0, 0, 0, "rst_busy");
        exp_at(0, 1, 0, "rst_in_packet");
        exp_at(0, 2, 0, "rst_pkt_cnt");
        exp_at(0, 3, 0, "rst_err_cnt");
        exp_at(0, 4, 0, "rst_stall_cnt");
        resetn = 1'b1;
        step();

        // Four-beat packet
        beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0, 1'b0);
        exp_at(0, 1, 0, "a_inpkt_beat1");
        exp_at(1, 1, 1, "a_inpkt_beat2");
        step();
        beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0, 1'b0);
        step();
        beat(64'h3333_3333_3333_3333, 8'hFF, 1'b0, 1'b0);
        exp_at(0, 1, 1, "a_inpkt_beat3");
        step();
        beat(64'h4444_4444_4444_4444, 8'h0F, 1'b1, 1'b0);
        exp_at(0, 1, 1, "a_inpkt_beat4");
        exp_at(0, 2, 0, "a_pkt_before_last");
        exp_at(1, 1, 0, "a_inpkt_after");
        exp_at(1, 2, 1, "a_pkt_cnt");
        exp_at(1, 3, 0, "a_err_cnt");
        step();
        idle();
        repeat (20) step();

        // One-cycle tvalid pulse: busy high for exactly 17 cycles
        beat(64'h5555_5555_5555_5555, 8'hFF, 1'b1, 1'b0);
        exp_at(0, 0, 0, "b_busy_before");
        for (int i = 1; i <= 17; i++) exp_at(i, 0, 1, "b_busy_hold");
        exp_at(18, 0, 0, "b_busy_fall");
        step();
        idle();
        repeat (20) step();

        // Five stall cycles, then accept; stream must be unchanged
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            beat(64'h6666_0000_DEAD_BEEF, 8'hFF, 1'b1, 1'b0);
            exp_at(0, 5, 0, "c_tready_low");
            step();
        end
        m_tready = 1'b1;
        beat(64'h6666_0000_DEAD_BEEF, 8'hFF, 1'b1, 1'b0);
        exp_at(0, 5, 1, "c_tready_high");
        exp_at(0, 4, 5, "c_stall_cnt");
        exp_at(1, 4, 5, "c_stall_hold");
        exp_at(1, 2, 3, "c_pkt_cnt");
        exp_at(1, 1, 0, "c_inpkt_single");
        step();
        idle();
        step();

        // clear_stats coinciding with an accepted tlast
        beat(64'h7777_7777_7777_7777, 8'hFF, 1'b1, 1'b1);
        clear_stats = 1'b1;
        exp_at(1, 2, 0, "d_pkt_cleared");
        exp_at(1, 3, 0, "d_err_cleared");
        exp_at(1, 4, 0, "d_stall_cleared");
        step();
        clear_stats = 1'b0;
        idle();
        step();

        // Saturation with 4-bit counters
        for (int i = 0; i < 20; i++) begin
            beat(64'h8800_0000_0000_0000 + 64'(i), 8'h01, 1'b1, 1'b1);
            if (i == 13) exp_at(1, 2, 14, "e_pkt_14");
            if (i == 14) exp_at(1, 3, 15, "e_err_15");
            step();
        end
        idle();
        exp_at(0, 2, 15, "e_pkt_sat");
        exp_at(0, 3, 15, "e_err_sat");
        step();

        // Reset during beat 2 of a packet
        beat(64'h9999_9999_9999_9999, 8'hFF, 1'b0, 1'b0);
        exp_at(1, 1, 1, "f_inpkt_beat1");
        step();
        beat(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0, 1'b0);
        resetn = 1'b0;
        exp_at(1, 1, 0, "f_inpkt_reset");
        exp_at(1, 2, 0, "f_pkt_reset");
        exp_at(1, 3, 0, "f_err_reset");
        exp_at(1, 4, 0, "f_stall_reset");
        exp_at(1, 0, 0, "f_busy_reset");
        step();
        resetn = 1'b1;
        beat(64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b0, 1'b0);
        exp_at(1, 1, 1, "f_inpkt_restart");
        step();
        beat(64'hCCCC_CCCC_CCCC_CCCC, 8'h3F, 1'b1, 1'b0);
        exp_at(1, 2, 1, "f_pkt_after");
        exp_at(1, 1, 0, "f_inpkt_done");
        step();
        idle();
        repeat (5) step();

        foreach (sq[i]) begin
            nchecks++;
            nerrors++;
            $display("FAIL %s: got no check, required check at cycle %0d", sq[i].name, sq[i].cyc);
        end
        foreach (bq[i]) begin
            nchecks++;
            nerrors++;
            $display("FAIL beat_missing: got nothing, required %h", bq[i]);
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors + 1);
        $fatal(1, "timeout");
    end

endmodule : tb_eth_activity_monitor
`default_nettype wire
